// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_AWIDTH         = 14;
  localparam int unsigned DEF_DWIDTH         = 32;
  localparam int unsigned DEF_MAX_DATA_BURST = 4;
  localparam int unsigned BURST_W            = 4;
  localparam int unsigned STALL_W            = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_DATA  = 1'b0,
    PRI_FETCH = 1'b1
  } arb_state_e;

  // Keeps an out-of-range burst parameter inside what burst_cnt can reach.
  function automatic logic [BURST_W-1:0] burst_limit(input int unsigned max_burst);
    if (max_burst < 1) begin
      return BURST_W'(1);
    end
    if (max_burst > 15) begin
      return BURST_W'(15);
    end
    return BURST_W'(max_burst);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_stall_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module arb_stall_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous RAM,
// with bounded data bursts so fetch cannot starve.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH         = DEF_AWIDTH,
  parameter int unsigned DWIDTH         = DEF_DWIDTH,
  parameter int unsigned MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  input  logic [AWIDTH-1:0]     if_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [DWIDTH-1:0]     if_rdata,

  input  logic                  dm_req_valid,
  input  logic [AWIDTH-1:0]     dm_addr,
  input  logic [DWIDTH-1:0]     dm_wdata,
  input  logic [DWIDTH/8-1:0]   dm_we,
  output logic                  dm_req_ready,
  output logic                  dm_resp_valid,
  output logic [DWIDTH-1:0]     dm_rdata,

  output logic                  mem_en,
  output logic [DWIDTH/8-1:0]   mem_we,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic [DWIDTH-1:0]     mem_rdata,

  output logic [STALL_W-1:0]    fetch_stall_cnt
);

  localparam logic [BURST_W-1:0] BURST_LIMIT = burst_limit(MAX_DATA_BURST);

  arb_state_e          state_q, state_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  owner_e              owner_q, owner_d;

  logic grant_if;
  logic grant_dm;
  logic fetch_stalled;

  // Grants are masked while reset is low so no handshake can complete then.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (rst) begin
      if (state_q == PRI_FETCH) begin
        grant_if = if_req_valid;
        grant_dm = dm_req_valid & ~if_req_valid;
      end else begin
        grant_dm = dm_req_valid;
        grant_if = if_req_valid & ~dm_req_valid;
      end
    end
  end

  assign if_req_ready  = grant_if;
  assign dm_req_ready  = grant_dm;
  assign fetch_stalled = if_req_valid & ~grant_if;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      PRI_DATA: begin
        if (!if_req_valid) begin
          burst_d = '0;
        end else if (grant_dm) begin
          burst_d = burst_q + BURST_W'(1);
          if (burst_d == BURST_LIMIT) begin
            state_d = PRI_FETCH;
          end
        end else begin
          burst_d = '0;
        end
      end
      PRI_FETCH: begin
        state_d = PRI_DATA;
        burst_d = '0;
      end
      default: begin
        state_d = PRI_DATA;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (grant_if) begin
      owner_d = OWN_FETCH;
    end else if (grant_dm && (dm_we == '0)) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PRI_DATA;
      burst_q <= '0;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    mem_en    = grant_if | grant_dm;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_dm) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end
  end

  assign if_resp_valid = (owner_q == OWN_FETCH);
  assign dm_resp_valid = (owner_q == OWN_DATA);
  assign if_rdata      = mem_rdata;
  assign dm_rdata      = mem_rdata;

  arb_stall_counter #(
    .WIDTH (STALL_W)
  ) u_stall (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (fetch_stalled),
    .cnt_o  (fetch_stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid;
  logic [AW-1:0] if_addr;
  logic          if_req_ready;
  logic          if_resp_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_we;
  logic          dm_req_ready;
  logic          dm_resp_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   fetch_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mem_port_arbiter #(
    .AWIDTH         (AW),
    .DWIDTH         (DW),
    .MAX_DATA_BURST (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_valid    (if_req_valid),
    .if_addr         (if_addr),
    .if_req_ready    (if_req_ready),
    .if_resp_valid   (if_resp_valid),
    .if_rdata        (if_rdata),
    .dm_req_valid    (dm_req_valid),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_we           (dm_we),
    .dm_req_ready    (dm_req_ready),
    .dm_resp_valid   (dm_resp_valid),
    .dm_rdata        (dm_rdata),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .fetch_stall_cnt (fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        is_f;
    logic [31:0] exp_stall;

    rst = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    dm_req_valid = 1'b0; dm_addr = '0; dm_wdata = '0; dm_we = '0;

    repeat (2) @(posedge clk);
    #1;
    // Valids high during reset must not produce readies or memory activity.
    if_req_valid = 1'b1; dm_req_valid = 1'b1; if_addr = 14'h010; dm_addr = 14'h020;
    #1;
    chk1("rst_if_ready", if_req_ready, 1'b0);
    chk1("rst_dm_ready", dm_req_ready, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk32("rst_mem_we", 32'(mem_we), 32'h0);
    chk1("rst_if_resp", if_resp_valid, 1'b0);
    chk1("rst_dm_resp", dm_resp_valid, 1'b0);
    chk32("rst_stall", fetch_stall_cnt, 32'h0);
    chk1("rst_state_fetch", dut.state_q == PRI_FETCH, 1'b0);
    chk32("rst_burst", 32'(dut.burst_q), 32'h0);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    rst = 1'b1;

    // Preload the instruction word through the data port.
    dm_req_valid = 1'b1; dm_addr = 14'h010; dm_we = 4'hF; dm_wdata = 32'h00A00093;
    #1;
    chk1("wr_dm_ready", dm_req_ready, 1'b1);
    chk1("wr_if_ready", if_req_ready, 1'b0);
    chk1("wr_mem_en", mem_en, 1'b1);
    chk32("wr_mem_we", 32'(mem_we), 32'hF);
    chk32("wr_mem_addr", 32'(mem_addr), 32'h010);
    chk32("wr_mem_wdata", mem_wdata, 32'h00A00093);
    @(posedge clk); #1;
    dm_req_valid = 1'b0; dm_we = '0;
    chk1("wr_no_dm_resp", dm_resp_valid, 1'b0);
    chk1("wr_no_if_resp", if_resp_valid, 1'b0);

    // Write then read back 0x020.
    dm_req_valid = 1'b1; dm_addr = 14'h020; dm_we = 4'hF; dm_wdata = 32'h12345678;
    @(posedge clk); #1;
    chk1("wr2_no_dm_resp", dm_resp_valid, 1'b0);
    dm_we = '0; dm_wdata = '0;
    #1;
    chk1("rd_dm_ready", dm_req_ready, 1'b1);
    chk1("rd_mem_en", mem_en, 1'b1);
    chk32("rd_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    chk1("rd_dm_resp", dm_resp_valid, 1'b1);
    chk32("rd_dm_rdata", dm_rdata, 32'h12345678);
    chk1("rd_if_resp", if_resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("rd_resp_single", dm_resp_valid, 1'b0);

    // Fetch-only read of 0x010.
    if_req_valid = 1'b1; if_addr = 14'h010;
    #1;
    chk1("f_if_ready", if_req_ready, 1'b1);
    chk1("f_dm_ready", dm_req_ready, 1'b0);
    chk32("f_mem_addr", 32'(mem_addr), 32'h010);
    chk32("f_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    chk1("f_if_resp", if_resp_valid, 1'b1);
    chk32("f_if_rdata", if_rdata, 32'h00A00093);
    chk1("f_dm_resp", dm_resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("f_resp_single", if_resp_valid, 1'b0);
    chk32("f_no_stall", fetch_stall_cnt, 32'h0);

    // Both ports busy: D,D,D,D,F repeating.
    exp_stall = 32'h0;
    if_req_valid = 1'b1; if_addr = 14'h010;
    dm_req_valid = 1'b1; dm_addr = 14'h020; dm_we = '0;
    for (int i = 0; i < 10; i++) begin
      is_f = (i % 5 == 4);
      #1;
      chk1("burst_if_ready", if_req_ready, is_f);
      chk1("burst_dm_ready", dm_req_ready, !is_f);
      @(posedge clk); #1;
      if (!is_f) exp_stall = exp_stall + 32'h1;
      chk1("burst_if_resp", if_resp_valid, is_f);
      chk1("burst_dm_resp", dm_resp_valid, !is_f);
      chk32("burst_rdata", if_rdata, is_f ? 32'h00A00093 : 32'h12345678);
      chk32("burst_stall", fetch_stall_cnt, exp_stall);
      if (i == 4) chk32("stall_after_first_fetch", fetch_stall_cnt, 32'd4);
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;

    // Data-only traffic stays in PRI_DATA with burst_cnt at zero.
    dm_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk1("donly_dm_ready", dm_req_ready, 1'b1);
      @(posedge clk); #1;
      chk1("donly_state_fetch", dut.state_q == PRI_FETCH, 1'b0);
      chk32("donly_burst", 32'(dut.burst_q), 32'h0);
    end
    dm_req_valid = 1'b0;
    chk32("donly_stall_held", fetch_stall_cnt, 32'd8);

    // Saturation: preload near the top, then stall fetch three cycles.
    force dut.u_stall.cnt_d = 32'hFFFFFFFD;
    @(posedge clk); #1;
    release dut.u_stall.cnt_d;
    chk32("sat_preload", fetch_stall_cnt, 32'hFFFFFFFD);
    if_req_valid = 1'b1; dm_req_valid = 1'b1;
    @(posedge clk); #1;
    chk32("sat_1", fetch_stall_cnt, 32'hFFFFFFFE);
    @(posedge clk); #1;
    chk32("sat_2", fetch_stall_cnt, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk32("sat_3", fetch_stall_cnt, 32'hFFFFFFFF);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;

    // Reset right after a fetch read is accepted drops its response.
    if_req_valid = 1'b1; if_addr = 14'h010;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk1("mr_if_resp", if_resp_valid, 1'b0);
    chk32("mr_stall", fetch_stall_cnt, 32'h0);
    chk1("mr_state_fetch", dut.state_q == PRI_FETCH, 1'b0);
    chk32("mr_burst", 32'(dut.burst_q), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("mr_rel_if_resp", if_resp_valid, 1'b0);
    chk1("mr_rel_dm_resp", dm_resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("mr_post_if_resp", if_resp_valid, 1'b0);
    chk32("mr_post_stall", fetch_stall_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 14, word address width of the shared memory.
REQ-002 SHALL have parameter DWIDTH, default 32, data width.
REQ-003 SHALL have parameter MAX_DATA_BURST, default 4, max consecutive data grants while fetch waits (range 1..15).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports if_req_valid in 1, if_addr in AWIDTH, if_req_ready out 1: fetch request handshake.
REQ-007 SHALL have ports if_resp_valid out 1, if_rdata out DWIDTH: fetch read response.
REQ-008 SHALL have ports dm_req_valid in 1, dm_addr in AWIDTH, dm_wdata in DWIDTH, dm_we in DWIDTH/8: data request; dm_we==0 means read.
REQ-009 SHALL have ports dm_req_ready out 1, dm_resp_valid out 1, dm_rdata out DWIDTH: data handshake and read response.
REQ-010 SHALL have ports mem_en out 1, mem_we out DWIDTH/8, mem_addr out AWIDTH, mem_wdata out DWIDTH, mem_rdata in DWIDTH: single-port sync RAM, 1-cycle read latency.
REQ-011 SHALL have port fetch_stall_cnt out 32: saturating count of cycles with if_req_valid high and if_req_ready low.

Function
REQ-012 Request accepted when valid && ready in same cycle; at most one acceptance per cycle.
REQ-013 Grant decision combinational from current valids and arbitration state; ready high only on granted port, never on both.
REQ-014 Ready on a port SHALL not depend on that port's own valid being low (no valid->ready->valid loop issue; ready = grant computed including valid).
REQ-015 On acceptance: mem_en=1, mem_addr/mem_we/mem_wdata from granted port (mem_we=0 for fetch); otherwise mem_en=0, mem_we=0.
REQ-016 Read accepted at cycle t: owning port's resp_valid=1 exactly at t+1, rdata=mem_rdata; other port's resp_valid=0.
REQ-017 Writes (dm_we!=0) SHALL produce no response pulse.
REQ-018 if_rdata and dm_rdata SHALL both be driven from mem_rdata; only resp_valid distinguishes owner.
REQ-019 Registered owner tag {none, fetch, data} captured at acceptance for REQ-016.
REQ-020 Arbitration FSM states: PRI_DATA (reset), PRI_FETCH.
REQ-021 PRI_DATA: data granted if dm_req_valid, else fetch if if_req_valid.
REQ-022 4-bit counter burst_cnt increments on each data grant while if_req_valid=1; clears when fetch granted or if_req_valid=0.
REQ-023 PRI_DATA -> PRI_FETCH when a data grant makes burst_cnt reach MAX_DATA_BURST.
REQ-024 PRI_FETCH: fetch granted if if_req_valid; else data granted if dm_req_valid; state returns to PRI_DATA and burst_cnt clears at end of any PRI_FETCH cycle.
REQ-025 Fetch worst-case wait with continuous data traffic: MAX_DATA_BURST cycles.
REQ-026 Simultaneous same-cycle requests: resolved by REQ-021/024; loser's ready low, request must be held stable until accepted.
REQ-027 fetch_stall_cnt holds at 32'hFFFFFFFF, never wraps.

Reset
REQ-028 While rst=0: state PRI_DATA, burst_cnt=0, owner tag none, fetch_stall_cnt=0, all ready/resp_valid/mem_en/mem_we outputs 0.
REQ-029 Reset mid-transaction drops any pending read response; no resp_valid in first cycle after release.
REQ-030 Request acceptance allowed from first rising edge after reset deassertion.

Structure
REQ-031 Shared package holds owner-tag enum, FSM state enum and default parameter constants.
REQ-032 One sub-module natural: arb_stall_counter (32-bit saturating counter with enable).
REQ-033 Memory itself is outside the block; no combinational path mem_rdata -> mem_* outputs.

Verification
REQ-034 Fetch only, read addr 0x010 containing 0x00A00093 -> if_req_ready same cycle, if_resp_valid next cycle with if_rdata=0x00A00093.
REQ-035 Both valid continuously, MAX_DATA_BURST=4 -> grant pattern D,D,D,D,F repeating; fetch_stall_cnt=4 after first fetch grant.
REQ-036 Data write addr 0x020, dm_we=4'hF, wdata=0x12345678, then read same addr -> no resp after write, dm_resp_valid with 0x12345678 after read.
REQ-037 rst=0 asserted cycle after a fetch read accepted -> if_resp_valid stays 0, all counters 0 after release.
REQ-038 Force fetch_stall_cnt near 0xFFFFFFFE, hold fetch stalled 3 cycles -> value stays 0xFFFFFFFF.
REQ-039 Data only, fetch idle -> dm_req_ready every cycle, state never leaves PRI_DATA, burst_cnt stays 0.
